// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - handshake bundle between fetch, the immediate stage and register read
interface imm_gen_stage_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_imm;
    logic [2:0]        out_fmt;
    logic              out_unknown;
    logic [TAG_W-1:0]  out_tag;

    // Environment side: drives instructions in and accepts immediates out.
    modport master (
        output in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_unknown, out_tag
    );

    // Stage side.
    modport slave (
        input  in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_unknown, out_tag
    );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - RV32I/RV64I immediate decode feeding a DEPTH-entry output FIFO (optional IMM_GEN_ZICSR_EN)
module imm_gen_stage #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    imm_gen_stage_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] FMT_Z     = 3'd7;
`endif

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic [31:0]      inst;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             is_shift;

    logic [XLEN-1:0]  dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_unknown;

    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [2:0]       fmt_q [DEPTH];
    logic             unk_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             in_ready_w;
    logic             out_valid_w;
    logic             push;
    logic             pop;

    assign inst     = bus.in_inst;
    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Decode the incoming word; sign-extended formats fill with inst[31] then overlay the low field.
    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_unknown = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                dec_imm       = {XLEN{inst[31]}};
                dec_imm[11:0] = inst[31:20];
                dec_fmt       = FMT_I;
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    // RV32 shifts only have a 5-bit shamt; inst[25] belongs to funct7 there.
                    dec_imm[5:0] = {(XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};
                    dec_fmt      = FMT_SHAMT;
                end else begin
                    dec_imm       = {XLEN{inst[31]}};
                    dec_imm[11:0] = inst[31:20];
                    dec_fmt       = FMT_I;
                end
            end
            OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec_imm[4:0] = inst[24:20];
                        dec_fmt      = FMT_SHAMT;
                    end else begin
                        dec_imm       = {XLEN{inst[31]}};
                        dec_imm[11:0] = inst[31:20];
                        dec_fmt       = FMT_I;
                    end
                end else begin
                    dec_unknown = 1'b1;
                end
            end
            OPC_STORE: begin
                dec_imm       = {XLEN{inst[31]}};
                dec_imm[11:0] = {inst[31:25], inst[11:7]};
                dec_fmt       = FMT_S;
            end
            OPC_BRANCH: begin
                dec_imm       = {XLEN{inst[31]}};
                dec_imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                dec_fmt       = FMT_B;
            end
            OPC_JAL: begin
                dec_imm       = {XLEN{inst[31]}};
                dec_imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                dec_fmt       = FMT_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm       = {XLEN{inst[31]}};
                dec_imm[31:0] = {inst[31:12], 12'b0};
                dec_fmt       = FMT_U;
            end
            OPC_OP, OPC_OP32, OPC_FENCE: begin
                dec_fmt = FMT_NONE;
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
                // CSR*I forms carry a 5-bit unsigned immediate in the rs1 field.
                if (funct3[2]) begin
                    dec_imm[4:0] = inst[19:15];
                    dec_fmt      = FMT_Z;
                end
`else
                dec_fmt = FMT_NONE;
`endif
            end
            default: begin
                dec_unknown = 1'b1;
            end
        endcase
    end

    // Ready depends only on the registered count so out_ready never reaches in_ready.
    assign in_ready_w  = (count_q != FULL_CNT);
    assign out_valid_w = (count_q != '0);
    assign push        = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready;

    // Next pointer/count state; flush discards everything including this cycle's push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Buffer storage holds decoded results only; cleared on reset so idle outputs read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                imm_q[i] <= '0;
                fmt_q[i] <= '0;
                unk_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else if (push && !flush) begin
            imm_q[wr_ptr_q] <= dec_imm;
            fmt_q[wr_ptr_q] <= dec_fmt;
            unk_q[wr_ptr_q] <= dec_unknown;
            tag_q[wr_ptr_q] <= bus.in_tag;
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_w;
    assign bus.out_imm     = imm_q[rd_ptr_q];
    assign bus.out_fmt     = fmt_q[rd_ptr_q];
    assign bus.out_unknown = unk_q[rd_ptr_q];
    assign bus.out_tag     = tag_q[rd_ptr_q];
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - scoreboard bench driving XLEN=64 and XLEN=32 instances in lockstep
module tb_imm_gen_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(64), .TAG_W(5)) if64 ();
    imm_gen_stage_if #(.XLEN(32), .TAG_W(5)) if32 ();

    imm_gen_stage #(.XLEN(64), .TAG_W(5), .DEPTH(2)) u_dut64 (
        .clk(clk), .reset(reset), .flush(flush), .bus(if64)
    );
    imm_gen_stage #(.XLEN(32), .TAG_W(5), .DEPTH(2)) u_dut32 (
        .clk(clk), .reset(reset), .flush(flush), .bus(if32)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        unk;
        logic [4:0]  tag;
    } entry_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] i64;
        logic [2:0]  f64;
        logic        u64;
        logic [31:0] i32;
        logic [2:0]  f32;
        logic        u32;
    } vec_t;

    entry_t exp64[$], exp32[$], got64[$], got32[$];
    vec_t   vecs[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic entry_t ref_decode(input logic [31:0] w, input int xl, input logic [4:0] t);
        entry_t e;
        logic [63:0] v;
        v = '0;
        e.fmt = 3'd0;
        e.unk = 1'b0;
        e.tag = t;
        case (w[6:0])
            7'h03, 7'h67: begin v = 64'($signed(w[31:20])); e.fmt = 3'd1; end
            7'h13: begin
                if (w[13:12] == 2'b01) begin
                    v = (xl == 64) ? {58'b0, w[25:20]} : {59'b0, w[24:20]};
                    e.fmt = 3'd6;
                end else begin
                    v = 64'($signed(w[31:20])); e.fmt = 3'd1;
                end
            end
            7'h1B: begin
                if (xl != 64) e.unk = 1'b1;
                else if (w[13:12] == 2'b01) begin v = {59'b0, w[24:20]}; e.fmt = 3'd6; end
                else begin v = 64'($signed(w[31:20])); e.fmt = 3'd1; end
            end
            7'h23: begin v = 64'($signed({w[31:25], w[11:7]})); e.fmt = 3'd2; end
            7'h63: begin v = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); e.fmt = 3'd3; end
            7'h6F: begin v = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); e.fmt = 3'd5; end
            7'h37, 7'h17: begin v = 64'($signed({w[31:12], 12'h000})); e.fmt = 3'd4; end
            7'h33, 7'h3B, 7'h0F: e.fmt = 3'd0;
            7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
                if (w[14]) begin v = {59'b0, w[19:15]}; e.fmt = 3'd7; end
`endif
            end
            default: e.unk = 1'b1;
        endcase
        if (xl == 32) v[63:32] = '0;
        e.imm = v;
        return e;
    endfunction

    // Collect every entry the DUTs hand over; flush/reset cycles carry no valid handshake.
    always @(negedge clk) begin
        if (!reset && !flush) begin
            if (if64.out_valid && if64.out_ready)
                got64.push_back('{if64.out_imm, if64.out_fmt, if64.out_unknown, if64.out_tag});
            if (if32.out_valid && if32.out_ready)
                got32.push_back('{{32'b0, if32.out_imm}, if32.out_fmt, if32.out_unknown, if32.out_tag});
        end
    end

    task automatic drive(input logic v, input logic [31:0] inst, input logic [4:0] tag, input logic rdy);
        if64.in_valid = v; if64.in_inst = inst; if64.in_tag = tag; if64.out_ready = rdy;
        if32.in_valid = v; if32.in_inst = inst; if32.in_tag = tag; if32.out_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp64.delete(); exp32.delete(); got64.delete(); got32.delete();
    endtask

    task automatic push_exp(input logic [31:0] inst, input logic [4:0] tag);
        exp64.push_back(ref_decode(inst, 64, tag));
        exp32.push_back(ref_decode(inst, 32, tag));
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        for (int c = 0; c < 64 && (got64.size() < exp64.size() || got32.size() < exp32.size()); c++)
            next_cycle();
        repeat (3) next_cycle();
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        reset = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", if64.out_valid); end
        n_checks++; if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", if64.in_ready); end
        n_checks++; if (if64.out_imm !== 64'h0) begin n_fail++; $display("FAIL reset_out_imm got %h exp 0", if64.out_imm); end
        n_checks++; if (if64.out_fmt !== 3'd0) begin n_fail++; $display("FAIL reset_out_fmt got %0d exp 0", if64.out_fmt); end
        n_checks++; if (if64.out_unknown !== 1'b0) begin n_fail++; $display("FAIL reset_out_unknown got %b exp 0", if64.out_unknown); end
        n_checks++; if (if64.out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_out_tag got %0d exp 0", if64.out_tag); end
        n_checks++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_x32 got valid=%b ready=%b exp 0/1", if32.out_valid, if32.in_ready); end
        next_cycle();
    endtask

    task automatic test_latency();
        clear_sb();
        drive(1'b1, 32'hFFF00093, 5'd9, 1'b1);
        @(negedge clk);
        n_checks++; if (if64.in_ready !== 1'b1 || if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_accept got ready=%b valid=%b exp 1/0", if64.in_ready, if64.out_valid); end
        next_cycle();
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        n_checks++; if (if64.out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b exp 1", if64.out_valid); end
        n_checks++; if (if64.out_imm !== 64'hFFFFFFFFFFFFFFFF || if64.out_fmt !== 3'd1 || if64.out_unknown !== 1'b0 || if64.out_tag !== 5'd9) begin
            n_fail++; $display("FAIL lat_addi64 got imm=%h fmt=%0d unk=%b tag=%0d exp ffffffffffffffff/1/0/9", if64.out_imm, if64.out_fmt, if64.out_unknown, if64.out_tag);
        end
        n_checks++; if (if32.out_imm !== 32'hFFFFFFFF || if32.out_fmt !== 3'd1) begin
            n_fail++; $display("FAIL lat_addi32 got imm=%h fmt=%0d exp ffffffff/1", if32.out_imm, if32.out_fmt);
        end
        next_cycle();
        clear_sb();
    endtask

    task automatic test_vectors();
        logic acc;
        entry_t e, g;
        clear_sb();
        vecs.delete();
        vecs.push_back('{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC, 3'd3, 1'b0});
        vecs.push_back('{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0});
        vecs.push_back('{32'h43F0D093, 64'd63, 3'd6, 1'b0, 32'd31, 3'd6, 1'b0});
        vecs.push_back('{32'h0000001B, 64'd0, 3'd1, 1'b0, 32'd0, 3'd0, 1'b1});
        vecs.push_back('{32'hFE20AC23, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 32'hFFFFFFF8, 3'd2, 1'b0});
        vecs.push_back('{32'h0080006F, 64'd8, 3'd5, 1'b0, 32'd8, 3'd5, 1'b0});
        vecs.push_back('{32'h002081B3, 64'd0, 3'd0, 1'b0, 32'd0, 3'd0, 1'b0});
        vecs.push_back('{32'h0000007F, 64'd0, 3'd0, 1'b1, 32'd0, 3'd0, 1'b1});
        vecs.push_back('{32'h7FF12083, 64'h7FF, 3'd1, 1'b0, 32'h7FF, 3'd1, 1'b0});
        vecs.push_back('{32'h12345017, 64'h12345000, 3'd4, 1'b0, 32'h12345000, 3'd4, 1'b0});
        vecs.push_back('{32'h02009093, 64'd32, 3'd6, 1'b0, 32'd0, 3'd6, 1'b0});
        vecs.push_back('{32'h0010909B, 64'd1, 3'd6, 1'b0, 32'd0, 3'd0, 1'b1});
`ifdef IMM_GEN_ZICSR_EN
        vecs.push_back('{32'h300FD0F3, 64'd31, 3'd7, 1'b0, 32'd31, 3'd7, 1'b0});
`else
        vecs.push_back('{32'h300FD0F3, 64'd0, 3'd0, 1'b0, 32'd0, 3'd0, 1'b0});
`endif
        foreach (vecs[k]) begin
            drive(1'b1, vecs[k].inst, 5'(k), 1'b1);
            acc = 1'b0;
            for (int w = 0; w < 20 && !acc; w++) begin
                @(negedge clk);
                if (if64.in_ready) begin
                    acc = 1'b1;
                    exp64.push_back('{vecs[k].i64, vecs[k].f64, vecs[k].u64, 5'(k)});
                    exp32.push_back('{{32'b0, vecs[k].i32}, vecs[k].f32, vecs[k].u32, 5'(k)});
                end
                next_cycle();
            end
            n_checks++; if (!acc) begin n_fail++; $display("FAIL vec_accept idx=%0d got no in_ready exp accept", k); end
        end
        drain();
        n_checks++; if (got64.size() != exp64.size() || got32.size() != exp32.size()) begin
            n_fail++; $display("FAIL vec_count got %0d/%0d exp %0d/%0d", got64.size(), got32.size(), exp64.size(), exp32.size());
        end
        while (exp64.size() > 0 && got64.size() > 0) begin
            e = exp64.pop_front(); g = got64.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL vec64 got imm=%h fmt=%0d unk=%b tag=%0d exp imm=%h fmt=%0d unk=%b tag=%0d", g.imm, g.fmt, g.unk, g.tag, e.imm, e.fmt, e.unk, e.tag); end
        end
        while (exp32.size() > 0 && got32.size() > 0) begin
            e = exp32.pop_front(); g = got32.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL vec32 got imm=%h fmt=%0d unk=%b tag=%0d exp imm=%h fmt=%0d unk=%b tag=%0d", g.imm, g.fmt, g.unk, g.tag, e.imm, e.fmt, e.unk, e.tag); end
        end
        clear_sb();
    endtask

    task automatic test_random();
        logic [6:0] opcs [16];
        logic [31:0] w;
        entry_t e, g;
        opcs = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h6F, 7'h37,
                 7'h17, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h7F, 7'h00, 7'h5B};
        clear_sb();
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            w[6:0] = opcs[$urandom_range(0, 15)];
            drive(1'($urandom_range(0, 3) != 0), w, 5'(i), 1'($urandom_range(0, 3) != 0));
            @(negedge clk);
            if (if64.in_valid && if64.in_ready) push_exp(if64.in_inst, if64.in_tag);
            next_cycle();
        end
        drain();
        n_checks++; if (got64.size() != exp64.size() || got32.size() != exp32.size()) begin
            n_fail++; $display("FAIL rnd_count got %0d/%0d exp %0d/%0d", got64.size(), got32.size(), exp64.size(), exp32.size());
        end
        while (exp64.size() > 0 && got64.size() > 0) begin
            e = exp64.pop_front(); g = got64.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL rnd64 got imm=%h fmt=%0d unk=%b tag=%0d exp imm=%h fmt=%0d unk=%b tag=%0d", g.imm, g.fmt, g.unk, g.tag, e.imm, e.fmt, e.unk, e.tag); end
        end
        while (exp32.size() > 0 && got32.size() > 0) begin
            e = exp32.pop_front(); g = got32.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL rnd32 got imm=%h fmt=%0d unk=%b tag=%0d exp imm=%h fmt=%0d unk=%b tag=%0d", g.imm, g.fmt, g.unk, g.tag, e.imm, e.fmt, e.unk, e.tag); end
        end
        clear_sb();
    endtask

    task automatic test_backpressure();
        logic acc;
        logic [4:0] want [3];
        entry_t g;
        want = '{5'd1, 5'd2, 5'd3};
        clear_sb();
        for (int t = 1; t <= 2; t++) begin
            drive(1'b1, 32'h00000093 | (32'(t) << 20), 5'(t), 1'b0);
            @(negedge clk);
            n_checks++; if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept tag=%0d got in_ready %b exp 1", t, if64.in_ready); end
            next_cycle();
        end
        drive(1'b1, 32'h00300093, 5'd3, 1'b0);
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            n_checks++; if (if64.in_ready !== 1'b0 || if32.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got in_ready %b/%b exp 0", if64.in_ready, if32.in_ready); end
            n_checks++; if (if64.out_valid !== 1'b1 || if64.out_tag !== 5'd1) begin n_fail++; $display("FAIL bp_head got valid=%b tag=%0d exp 1/1", if64.out_valid, if64.out_tag); end
            next_cycle();
        end
        if64.out_ready = 1'b1; if32.out_ready = 1'b1;
        acc = 1'b0;
        for (int w = 0; w < 10 && !acc; w++) begin
            @(negedge clk);
            if (if64.in_ready) acc = 1'b1;
            next_cycle();
        end
        n_checks++; if (!acc) begin n_fail++; $display("FAIL bp_tag3 got no accept exp accept"); end
        drain();
        n_checks++; if (got64.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d exp 3", got64.size()); end
        for (int k = 0; k < 3 && got64.size() > 0; k++) begin
            g = got64.pop_front();
            n_checks++; if (g.tag !== want[k] || g.imm !== 64'(want[k])) begin n_fail++; $display("FAIL bp_order idx=%0d got tag=%0d imm=%h exp tag=%0d", k, g.tag, g.imm, want[k]); end
        end
        clear_sb();
    endtask

    task automatic test_flush();
        entry_t g;
        clear_sb();
        for (int t = 4; t <= 5; t++) begin
            drive(1'b1, 32'h00100093, 5'(t), 1'b0);
            next_cycle();
        end
        @(negedge clk);
        n_checks++; if (if64.in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_full got in_ready %b exp 0", if64.in_ready); end
        drive(1'b1, 32'h00100093, 5'd6, 1'b1);
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        n_checks++; if (if64.out_valid !== 1'b0 || if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got %b/%b exp 0", if64.out_valid, if32.out_valid); end
        n_checks++; if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready got %b exp 1", if64.in_ready); end
        next_cycle();
        drive(1'b1, 32'h00700093, 5'd7, 1'b1);
        next_cycle();
        drain();
        n_checks++; if (got64.size() != 1) begin n_fail++; $display("FAIL fl_count got %0d exp 1", got64.size()); end
        if (got64.size() > 0) begin
            g = got64.pop_front();
            n_checks++; if (g.tag !== 5'd7 || g.imm !== 64'd7) begin n_fail++; $display("FAIL fl_tag got tag=%0d imm=%h exp 7", g.tag, g.imm); end
        end
        clear_sb();
        drive(1'b1, 32'h00800093, 5'd8, 1'b0);
        next_cycle();
        reset = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b exp 0", if64.out_valid); end
        next_cycle();
        drain();
        n_checks++; if (got64.size() != 0) begin n_fail++; $display("FAIL rst_mid_stale got %0d entries exp 0", got64.size()); end
        clear_sb();
    endtask

    initial begin
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        test_reset();
        test_latency();
        test_vectors();
        test_backpressure();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
